// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_pkg
//  Purpose  : Shared bundle widths, field offsets and occupancy encoding for
//             the pipeline stage registers.
//  Revision : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // IF/ID: IR + PC
    localparam int IFID_CTRL_W  = 2;
    localparam int IFID_DATA_W  = 64;

    // ID/EX: IR, PC, A, B, sign-extended immediate, destination register
    localparam int IDEX_CTRL_W  = 12;
    localparam int IDEX_DATA_W  = 165;

    // EX/MEM: ALU result, store data, PC, destination register
    localparam int EXMEM_CTRL_W = 5;
    localparam int EXMEM_DATA_W = 101;

    // MEM/WB: load data, ALU result, destination register
    localparam int MEMWB_CTRL_W = 2;
    localparam int MEMWB_DATA_W = 69;

    // ID/EX control bundle field offsets
    localparam int IDEX_REGWRITE_BIT = 0;
    localparam int IDEX_MEMREAD_BIT  = 1;
    localparam int IDEX_MEMWRITE_BIT = 2;
    localparam int IDEX_MEMTOREG_BIT = 3;
    localparam int IDEX_BRANCH_BIT   = 4;
    localparam int IDEX_ALUSRC_BIT   = 5;
    localparam int IDEX_REGDST_BIT   = 6;
    localparam int IDEX_JUMP_BIT     = 7;
    localparam int IDEX_ALUCTRL_LSB  = 8;
    localparam int IDEX_ALUCTRL_W    = 4;

    // ID/EX data bundle field offsets
    localparam int IDEX_DEST_LSB = 0;
    localparam int IDEX_SEXT_LSB = 5;
    localparam int IDEX_B_LSB    = 37;
    localparam int IDEX_A_LSB    = 69;
    localparam int IDEX_PC_LSB   = 101;
    localparam int IDEX_IR_LSB   = 133;

    localparam int OCC_W = 2;

    typedef enum logic [OCC_W-1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_e;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_skid_slot.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_skid_slot
//  Purpose  : One enable-loaded control+data register with a valid bit.
//             Clear drops the entry and zeroes control; data is held.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_skid_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W = IDEX_CTRL_W,
    parameter int DATA_W = IDEX_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid_q;
    logic              w_valid_d;
    logic [CTRL_W-1:0] r_ctrl_q;
    logic [CTRL_W-1:0] w_ctrl_d;
    logic [DATA_W-1:0] r_data_q;
    logic [DATA_W-1:0] w_data_d;

    always_comb begin
        w_valid_d = r_valid_q;
        w_ctrl_d  = r_ctrl_q;
        w_data_d  = r_data_q;
        if (i_clr) begin
            w_valid_d = 1'b0;
            w_ctrl_d  = '0;
        end else if (i_load) begin
            w_valid_d = 1'b1;
            w_ctrl_d  = i_ctrl;
            w_data_d  = i_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid_q <= 1'b0;
            r_ctrl_q  <= '0;
            r_data_q  <= '0;
        end else begin
            r_valid_q <= w_valid_d;
            r_ctrl_q  <= w_ctrl_d;
            r_data_q  <= w_data_d;
        end
    end

    assign o_valid = r_valid_q;
    assign o_ctrl  = r_ctrl_q;
    assign o_data  = r_data_q;

endmodule : pipe_skid_slot
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_reg
//  Purpose  : Valid/ready pipeline stage register with flush and an optional
//             2-entry skid buffer giving full throughput with registered ready.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int CTRL_W = IDEX_CTRL_W,
    parameter int DATA_W = IDEX_DATA_W,
    parameter bit SKID   = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [OCC_W-1:0]  occupancy
);

    logic              w_main_load;
    logic              w_main_clr;
    logic              w_main_valid;
    logic [CTRL_W-1:0] w_main_ctrl_src;
    logic [DATA_W-1:0] w_main_data_src;
    logic [CTRL_W-1:0] w_main_ctrl;
    logic [DATA_W-1:0] w_main_data;

    // The main slot is always the head entry presented downstream.
    pipe_skid_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clock   (clock),
        .reset   (reset),
        .i_clr   (w_main_clr),
        .i_load  (w_main_load),
        .i_ctrl  (w_main_ctrl_src),
        .i_data  (w_main_data_src),
        .o_valid (w_main_valid),
        .o_ctrl  (w_main_ctrl),
        .o_data  (w_main_data)
    );

    assign out_valid = w_main_valid;
    assign out_ctrl  = w_main_ctrl;
    assign out_data  = w_main_data;

    if (SKID) begin : g_skid
        occ_state_e        r_state_q;
        occ_state_e        w_state_d;
        logic              r_in_ready_q;
        logic              w_in_ready_d;
        logic              w_in_fire;
        logic              w_out_fire;
        logic              w_skid_load;
        logic              w_skid_clr;
        logic              w_skid_valid;
        logic [CTRL_W-1:0] w_skid_ctrl;
        logic [DATA_W-1:0] w_skid_data;

        assign w_in_fire  = in_valid & r_in_ready_q;
        assign w_out_fire = w_main_valid & out_ready;

        always_comb begin
            w_state_d   = r_state_q;
            w_main_load = 1'b0;
            w_main_clr  = 1'b0;
            w_skid_load = 1'b0;
            w_skid_clr  = 1'b0;
            if (flush) begin
                w_state_d  = OCC_EMPTY;
                w_main_clr = 1'b1;
                w_skid_clr = 1'b1;
            end else begin
                case (r_state_q)
                    OCC_EMPTY: begin
                        if (w_in_fire) begin
                            w_state_d   = OCC_ONE;
                            w_main_load = 1'b1;
                        end
                    end
                    OCC_ONE: begin
                        if (w_in_fire && w_out_fire) begin
                            w_main_load = 1'b1;
                        end else if (w_in_fire) begin
                            w_state_d   = OCC_TWO;
                            w_skid_load = 1'b1;
                        end else if (w_out_fire) begin
                            w_state_d  = OCC_EMPTY;
                            w_main_clr = 1'b1;
                        end
                    end
                    OCC_TWO: begin
                        if (w_out_fire) begin
                            w_state_d   = OCC_ONE;
                            w_main_load = 1'b1;
                            w_skid_clr  = 1'b1;
                        end
                    end
                    default: begin
                        w_state_d  = OCC_EMPTY;
                        w_main_clr = 1'b1;
                        w_skid_clr = 1'b1;
                    end
                endcase
            end
            w_in_ready_d = (w_state_d != OCC_TWO);
        end

        always_ff @(posedge clock) begin
            if (reset) begin
                r_state_q    <= OCC_EMPTY;
                r_in_ready_q <= 1'b1;
            end else begin
                r_state_q    <= w_state_d;
                r_in_ready_q <= w_in_ready_d;
            end
        end

        // Skid refills main when draining from TWO, otherwise main loads from input.
        assign w_main_ctrl_src = w_skid_valid ? w_skid_ctrl : in_ctrl;
        assign w_main_data_src = w_skid_valid ? w_skid_data : in_data;

        pipe_skid_slot #(
            .CTRL_W (CTRL_W),
            .DATA_W (DATA_W)
        ) u_skid (
            .clock   (clock),
            .reset   (reset),
            .i_clr   (w_skid_clr),
            .i_load  (w_skid_load),
            .i_ctrl  (in_ctrl),
            .i_data  (in_data),
            .o_valid (w_skid_valid),
            .o_ctrl  (w_skid_ctrl),
            .o_data  (w_skid_data)
        );

        assign in_ready  = r_in_ready_q;
        assign occupancy = r_state_q;
    end else begin : g_single
        logic w_in_ready;
        logic w_in_fire;
        logic w_out_fire;

        assign w_in_ready      = ~w_main_valid | out_ready;
        assign w_in_fire       = in_valid & w_in_ready;
        assign w_out_fire      = w_main_valid & out_ready;
        assign w_main_load     = ~flush & w_in_fire;
        assign w_main_clr      = flush | (w_out_fire & ~w_in_fire);
        assign w_main_ctrl_src = in_ctrl;
        assign w_main_data_src = in_data;
        assign in_ready        = w_in_ready;
        assign occupancy       = {1'b0, w_main_valid};
    end

endmodule : pipe_stage_reg
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_stage_reg
//  Purpose  : Self-checking bench for pipe_stage_reg, SKID=1 and SKID=0 side
//             by side against a queue-based reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int CW = 12;
    localparam int DW = 165;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          out_ready;
    logic          flush;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          in_ready1, out_valid1, in_ready0, out_valid0;
    logic [CW-1:0] out_ctrl1, out_ctrl0;
    logic [DW-1:0] out_data1, out_data0;
    logic [1:0]    occ1, occ0;

    int checks   = 0;
    int failures = 0;

    // Reference model: FIFO contents per DUT plus the last head data shown.
    logic [CW-1:0] mc1[$];
    logic [DW-1:0] md1[$];
    logic [CW-1:0] mc0[$];
    logic [DW-1:0] md0[$];
    logic [DW-1:0] shown1 = '0;
    logic [DW-1:0] shown0 = '0;

    always #5 clock = ~clock;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b1)) u_dut1 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready),
        .out_ctrl(out_ctrl1), .out_data(out_data1), .flush(flush), .occupancy(occ1)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1'b0)) u_dut0 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready),
        .out_ctrl(out_ctrl0), .out_data(out_data0), .flush(flush), .occupancy(occ0)
    );

    function automatic logic [DW-1:0] rand_data();
        logic [191:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[DW-1:0];
    endfunction

    // Advance one clock and apply the same transfer rules to the model.
    task automatic tick();
        bit rdy1, rdy0;
        rdy1 = (mc1.size() < 2);
        rdy0 = (mc0.size() == 0) || out_ready;
        @(posedge clock);
        if (reset) begin
            mc1.delete(); md1.delete(); mc0.delete(); md0.delete();
            shown1 = '0;
            shown0 = '0;
        end else if (flush) begin
            mc1.delete(); md1.delete(); mc0.delete(); md0.delete();
        end else begin
            if ((mc1.size() > 0) && out_ready) begin
                void'(mc1.pop_front()); void'(md1.pop_front());
            end
            if (in_valid && rdy1) begin
                mc1.push_back(in_ctrl); md1.push_back(in_data);
            end
            if ((mc0.size() > 0) && out_ready) begin
                void'(mc0.pop_front()); void'(md0.pop_front());
            end
            if (in_valid && rdy0) begin
                mc0.push_back(in_ctrl); md0.push_back(in_data);
            end
        end
        if (md1.size() > 0) shown1 = md1[0];
        if (md0.size() > 0) shown0 = md0[0];
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_ctrl = 12'hFFF; in_data = rand_data();
        out_ready = 1'b0; flush = 1'b0;
        tick();
        tick();
        checks++; if (out_valid1 !== 1'b0) begin failures++; $display("FAIL reset_out_valid1 got=%0b exp=0", out_valid1); end
        checks++; if (out_ctrl1 !== '0) begin failures++; $display("FAIL reset_out_ctrl1 got=%h exp=0", out_ctrl1); end
        checks++; if (occ1 !== 2'd0) begin failures++; $display("FAIL reset_occ1 got=%0d exp=0", occ1); end
        checks++; if (out_data1 !== '0) begin failures++; $display("FAIL reset_out_data1 got=%h exp=0", out_data1); end
        checks++; if (out_valid0 !== 1'b0) begin failures++; $display("FAIL reset_out_valid0 got=%0b exp=0", out_valid0); end
        checks++; if (out_ctrl0 !== '0) begin failures++; $display("FAIL reset_out_ctrl0 got=%h exp=0", out_ctrl0); end
        checks++; if (occ0 !== 2'd0) begin failures++; $display("FAIL reset_occ0 got=%0d exp=0", occ0); end
        reset = 1'b0; in_valid = 1'b0;
        #1;
        checks++; if (in_ready1 !== 1'b1) begin failures++; $display("FAIL reset_in_ready1 got=%0b exp=1", in_ready1); end
        checks++; if (in_ready0 !== 1'b1) begin failures++; $display("FAIL reset_in_ready0 got=%0b exp=1", in_ready0); end
    endtask

    task automatic test_streaming();
        out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_ctrl = CW'($urandom()); in_data = DW'(i);
            tick();
            checks++; if (out_valid1 !== 1'b1) begin failures++; $display("FAIL stream_valid1 i=%0d got=%0b exp=1", i, out_valid1); end
            checks++; if (out_data1 !== DW'(i)) begin failures++; $display("FAIL stream_data1 got=%0d exp=%0d", out_data1, i); end
            checks++; if (out_ctrl1 !== in_ctrl) begin failures++; $display("FAIL stream_ctrl1 got=%h exp=%h", out_ctrl1, in_ctrl); end
            checks++; if (occ1 !== 2'd1) begin failures++; $display("FAIL stream_occ1 i=%0d got=%0d exp=1", i, occ1); end
            checks++; if (out_data0 !== DW'(i)) begin failures++; $display("FAIL stream_data0 got=%0d exp=%0d", out_data0, i); end
            checks++; if (occ0 !== 2'd1) begin failures++; $display("FAIL stream_occ0 i=%0d got=%0d exp=1", i, occ0); end
        end
        in_valid = 1'b0;
        tick();
        checks++; if (occ1 !== 2'd0) begin failures++; $display("FAIL stream_drain_occ1 got=%0d exp=0", occ1); end
        checks++; if (out_valid0 !== 1'b0) begin failures++; $display("FAIL stream_drain_valid0 got=%0b exp=0", out_valid0); end
    endtask

    task automatic test_stall();
        logic [DW-1:0] a, b, c;
        a = rand_data(); b = rand_data(); c = rand_data();
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 12'h5A5;
        in_data = a; tick();
        checks++; if (out_data1 !== a || occ1 !== 2'd1) begin failures++; $display("FAIL stall_a1 occ got=%0d exp=1 data got=%h exp=%h", occ1, out_data1, a); end
        in_data = b; tick();
        checks++; if (occ1 !== 2'd2) begin failures++; $display("FAIL stall_occ2 got=%0d exp=2", occ1); end
        checks++; if (in_ready1 !== 1'b0) begin failures++; $display("FAIL stall_in_ready1 got=%0b exp=0", in_ready1); end
        in_data = c;
        repeat (2) begin
            tick();
            checks++; if (occ1 !== 2'd2 || out_data1 !== a) begin failures++; $display("FAIL stall_hold1 occ got=%0d exp=2 data got=%h exp=%h", occ1, out_data1, a); end
            checks++; if (out_ctrl1 !== 12'h5A5) begin failures++; $display("FAIL stall_ctrl1 got=%h exp=5a5", out_ctrl1); end
            checks++; if (occ0 !== 2'd1 || out_data0 !== a) begin failures++; $display("FAIL stall_hold0 occ got=%0d exp=1 data got=%h exp=%h", occ0, out_data0, a); end
        end
        out_ready = 1'b1;
        tick();
        checks++; if (out_data1 !== b || occ1 !== 2'd1) begin failures++; $display("FAIL stall_rel_b occ got=%0d exp=1 data got=%h exp=%h", occ1, out_data1, b); end
        checks++; if (out_data0 !== md0[0]) begin failures++; $display("FAIL stall_rel_data0 got=%h exp=%h", out_data0, md0[0]); end
        tick();
        checks++; if (out_data1 !== c || occ1 !== 2'd1) begin failures++; $display("FAIL stall_rel_c occ got=%0d exp=1 data got=%h exp=%h", occ1, out_data1, c); end
        in_valid = 1'b0;
        tick();
        checks++; if (occ1 !== 2'd0 || out_valid1 !== 1'b0) begin failures++; $display("FAIL stall_empty occ got=%0d valid got=%0b exp=0", occ1, out_valid1); end
        checks++; if (out_data1 !== c) begin failures++; $display("FAIL stall_keep_data got=%h exp=%h", out_data1, c); end
        checks++; if (out_ctrl1 !== '0) begin failures++; $display("FAIL stall_empty_ctrl got=%h exp=0", out_ctrl1); end
    endtask

    task automatic test_flush();
        logic [DW-1:0] e1, e2, d;
        e1 = rand_data(); e2 = rand_data(); d = rand_data();
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 12'hABC;
        in_data = e1; tick();
        in_data = e2; tick();
        checks++; if (occ1 !== 2'd2) begin failures++; $display("FAIL flush_pre_occ got=%0d exp=2", occ1); end
        flush = 1'b1; in_data = d; tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++; if (occ1 !== 2'd0 || out_valid1 !== 1'b0) begin failures++; $display("FAIL flush_state1 occ got=%0d valid got=%0b exp=0", occ1, out_valid1); end
        checks++; if (out_ctrl1 !== '0) begin failures++; $display("FAIL flush_ctrl1 got=%h exp=0", out_ctrl1); end
        checks++; if (out_data1 !== e1) begin failures++; $display("FAIL flush_data_held got=%h exp=%h", out_data1, e1); end
        checks++; if (in_ready1 !== 1'b1) begin failures++; $display("FAIL flush_in_ready1 got=%0b exp=1", in_ready1); end
        checks++; if (occ0 !== 2'd0 || out_valid0 !== 1'b0 || out_ctrl0 !== '0) begin failures++; $display("FAIL flush_state0 occ got=%0d valid got=%0b ctrl got=%h exp=0", occ0, out_valid0, out_ctrl0); end
        out_ready = 1'b1;
        repeat (3) begin
            tick();
            checks++; if (out_valid1 !== 1'b0 || out_valid0 !== 1'b0) begin failures++; $display("FAIL flush_no_d valid1 got=%0b valid0 got=%0b exp=0", out_valid1, out_valid0); end
        end
        flush = 1'b1; tick(); flush = 1'b0;
        checks++; if (occ1 !== 2'd0 || out_data1 !== e1) begin failures++; $display("FAIL flush_empty occ got=%0d data got=%h exp=%h", occ1, out_data1, e1); end
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] e, f;
        e = rand_data(); f = rand_data();
        out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 12'h3C3;
        in_data = e; tick();
        checks++; if (occ1 !== 2'd1 || occ0 !== 2'd1) begin failures++; $display("FAIL simul_first occ1 got=%0d occ0 got=%0d exp=1", occ1, occ0); end
        in_data = f; tick();
        checks++; if (occ1 !== 2'd1 || out_data1 !== f) begin failures++; $display("FAIL simul_skid occ got=%0d data got=%h exp=%h", occ1, out_data1, f); end
        checks++; if (occ0 !== 2'd1 || out_data0 !== f) begin failures++; $display("FAIL simul_single occ got=%0d data got=%h exp=%h", occ0, out_data0, f); end
        in_valid = 1'b0; tick();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 12'h0F0;
        in_data = rand_data(); tick();
        in_data = rand_data(); tick();
        checks++; if (occ1 !== 2'd2) begin failures++; $display("FAIL rmid_pre_occ got=%0d exp=2", occ1); end
        reset = 1'b1; tick();
        reset = 1'b0; in_valid = 1'b0;
        checks++; if (occ1 !== 2'd0 || out_valid1 !== 1'b0 || out_data1 !== '0) begin failures++; $display("FAIL rmid_state1 occ got=%0d valid got=%0b data got=%h exp=0", occ1, out_valid1, out_data1); end
        checks++; if (occ0 !== 2'd0 || out_valid0 !== 1'b0) begin failures++; $display("FAIL rmid_state0 occ got=%0d valid got=%0b exp=0", occ0, out_valid0); end
        out_ready = 1'b1;
        repeat (3) begin
            tick();
            checks++; if (out_valid1 !== 1'b0 || out_valid0 !== 1'b0) begin failures++; $display("FAIL rmid_stale valid1 got=%0b valid0 got=%0b exp=0", out_valid1, out_valid0); end
        end
    endtask

    task automatic test_random();
        logic          ev;
        logic [CW-1:0] ec;
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            reset     = ($urandom_range(0, 99) == 0);
            in_ctrl   = CW'($urandom());
            in_data   = rand_data();
            #1;
            checks++; if (in_ready1 !== (mc1.size() < 2)) begin failures++; $display("FAIL rnd_in_ready1 n=%0d got=%0b exp=%0b", n, in_ready1, mc1.size() < 2); end
            checks++; if (in_ready0 !== ((mc0.size() == 0) || out_ready)) begin failures++; $display("FAIL rnd_in_ready0 n=%0d got=%0b", n, in_ready0); end
            tick();
            ev = (mc1.size() > 0);
            ec = ev ? mc1[0] : '0;
            checks++; if (out_valid1 !== ev || out_ctrl1 !== ec) begin failures++; $display("FAIL rnd_head1 n=%0d valid got=%0b exp=%0b ctrl got=%h exp=%h", n, out_valid1, ev, out_ctrl1, ec); end
            checks++; if (out_data1 !== shown1) begin failures++; $display("FAIL rnd_data1 n=%0d got=%h exp=%h", n, out_data1, shown1); end
            checks++; if (occ1 !== 2'(mc1.size())) begin failures++; $display("FAIL rnd_occ1 n=%0d got=%0d exp=%0d", n, occ1, mc1.size()); end
            ev = (mc0.size() > 0);
            ec = ev ? mc0[0] : '0;
            checks++; if (out_valid0 !== ev || out_ctrl0 !== ec) begin failures++; $display("FAIL rnd_head0 n=%0d valid got=%0b exp=%0b ctrl got=%h exp=%h", n, out_valid0, ev, out_ctrl0, ec); end
            checks++; if (out_data0 !== shown0) begin failures++; $display("FAIL rnd_data0 n=%0d got=%h exp=%h", n, out_data0, shown0); end
            checks++; if (occ0 !== 2'(mc0.size())) begin failures++; $display("FAIL rnd_occ0 n=%0d got=%0d exp=%0d", n, occ0, mc0.size()); end
        end
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        in_ctrl = '0; in_data = '0;
        test_reset();
        test_streaming();
        test_stall();
        test_flush();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_pipe_stage_reg
`default_nettype wire
